yarp_dmem_bridge: RTL and testbench

//  Sits directly downstream of yarp_data_mem and is the consumer of its memory request.

---
 rtl/yarp_dmem_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_yarp_dmem_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_dmem_bridge.sv
// yarp_dmem_bridge: converts the single-cycle yarp_data_mem request into a
// word-aligned req/gnt/rvalid bus transaction with byte strobes, stalling the
// core until the access retires.
//
// Optional feature: define YARP_DMEM_TIMEOUT_EN to abort accesses that stay in
// REQ+WAIT for TIMEOUT_CYCLES cycles (bus_err_o pulses in the DONE cycle).
//
// Handshake: bus_req_o is held high with stable addr/we/strb/wdata until the
// cycle in which bus_gnt_i is sampled high; for loads, bus_rvalid_i is only
// honoured in WAIT, so stray rvalid in any other state is dropped.
module yarp_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_stall_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_strb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [3:0]  strb_req;
  logic        misalign_req;
  logic [31:0] lane_wdata;
  logic [31:0] aligned_rdata;

`ifdef YARP_DMEM_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [15:0] cnt_inc;
  logic        timeout_hit;

  // The access has spent its budget when this cycle brings the count to the limit.
  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (cnt_inc == TimeoutLimit);
`endif

  // Decode the incoming size into lane strobes and an alignment verdict.
  always_comb begin
    strb_req     = 4'b1111;
    misalign_req = 1'b0;
    case (data_mem_byte_en_i)
      2'b00: strb_req = 4'b0001 << data_mem_addr_i[1:0];
      2'b01: begin
        strb_req     = 4'b0011 << data_mem_addr_i[1:0];
        misalign_req = data_mem_addr_i[0];
      end
      default: misalign_req = |data_mem_addr_i[1:0];
    endcase
  end

  assign lane_wdata    = data_mem_wr_data_i << {data_mem_addr_i[1:0], 3'b000};
  assign aligned_rdata = bus_rdata_i >> {addr_q[1:0], 3'b000};

  // Next-state logic, request latching and load data capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
`ifdef YARP_DMEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = abort_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_mem_req_i && !misalign_req) begin
          addr_d  = data_mem_addr_i;
          we_d    = data_mem_wr_i;
          strb_d  = strb_req;
          wdata_d = lane_wdata;
          state_d = S_REQ;
`ifdef YARP_DMEM_TIMEOUT_EN
          cnt_d   = 16'd0;
          abort_d = 1'b0;
`endif
        end
      end
      S_REQ: begin
`ifdef YARP_DMEM_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (bus_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
`ifdef YARP_DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_DONE;
          abort_d = 1'b1;
          if (!we_q) rd_data_d = 32'd0;
        end
`endif
      end
      S_WAIT: begin
`ifdef YARP_DMEM_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (bus_rvalid_i) begin
          rd_data_d = aligned_rdata;
          state_d   = S_DONE;
        end
`ifdef YARP_DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d   = S_DONE;
          abort_d   = 1'b1;
          rd_data_d = 32'd0;
        end
`endif
      end
      default: begin
        // DONE: the core retires the access this cycle; inputs are ignored.
        state_d = S_IDLE;
`ifdef YARP_DMEM_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end
    endcase
  end

  // State and latched-request registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      strb_q    <= 4'd0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef YARP_DMEM_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 16'd0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign bus_err_o = (state_q == S_DONE) && abort_q;
`else
  assign bus_err_o = 1'b0;
`endif

  // Core-facing and bus-facing outputs derived from state and latched request.
  always_comb begin
    mem_stall_o = 1'b0;
    misalign_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        misalign_o  = data_mem_req_i && misalign_req;
        mem_stall_o = data_mem_req_i && !misalign_req;
      end
      S_REQ, S_WAIT: mem_stall_o = 1'b1;
      default: mem_stall_o = 1'b0;
    endcase
  end

  assign bus_req_o     = (state_q == S_REQ);
  assign bus_addr_o    = {addr_q[31:2], 2'b00};
  assign bus_we_o      = we_q;
  assign bus_strb_o    = strb_q;
  assign bus_wdata_o   = wdata_q;
  assign mem_rd_data_o = rd_data_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_yarp_dmem_bridge.sv
// tb_yarp_dmem_bridge: directed and randomized checks of yarp_dmem_bridge
// against a byte-count / shift arithmetic model of the access rules.
// Define YARP_DMEM_TIMEOUT_EN to also exercise the timeout abort (limit 4).
`timescale 1ns/1ps
module tb_yarp_dmem_bridge;

`ifdef YARP_DMEM_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_mem_req_i = 1'b0;
  logic [31:0] data_mem_addr_i = 32'd0;
  logic [1:0]  data_mem_byte_en_i = 2'd0;
  logic        data_mem_wr_i = 1'b0;
  logic [31:0] data_mem_wr_data_i = 32'd0;
  logic [31:0] mem_rd_data_o;
  logic        mem_stall_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_strb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic        bus_err_o;
  logic [1:0]  dbg_state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_rd = 32'd0;

  yarp_dmem_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .data_mem_req_i     (data_mem_req_i),
    .data_mem_addr_i    (data_mem_addr_i),
    .data_mem_byte_en_i (data_mem_byte_en_i),
    .data_mem_wr_i      (data_mem_wr_i),
    .data_mem_wr_data_i (data_mem_wr_data_i),
    .mem_rd_data_o      (mem_rd_data_o),
    .mem_stall_o        (mem_stall_o),
    .misalign_o         (misalign_o),
    .bus_req_o          (bus_req_o),
    .bus_addr_o         (bus_addr_o),
    .bus_we_o           (bus_we_o),
    .bus_strb_o         (bus_strb_o),
    .bus_wdata_o        (bus_wdata_o),
    .bus_gnt_i          (bus_gnt_i),
    .bus_rvalid_i       (bus_rvalid_i),
    .bus_rdata_i        (bus_rdata_i),
    .bus_err_o          (bus_err_o),
    .dbg_state_o        (dbg_state_o)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and the rules derived from it.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (8'(a % 4)));
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                           input logic [31:0] wd);
    data_mem_req_i     = 1'b1;
    data_mem_addr_i    = a;
    data_mem_byte_en_i = sz;
    data_mem_wr_i      = wr;
    data_mem_wr_data_i = wd;
  endtask

  // Aligned access: gnt after gd extra REQ cycles, rvalid in the (rd+1)th WAIT cycle.
  task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                        input logic [31:0] wd, input int gd, input int rd,
                        input logic [31:0] rdata);
    int stalls;
    logic [31:0] exp_wdata;
    exp_wdata = wd << (8 * (a % 4));
    if (!wr) exp_q.push_back(rdata >> (8 * (a % 4)));
    stalls = 0;
    drive_req(a, sz, wr, wd);
    @(negedge clk);
    if (mem_stall_o) stalls++;
    chk("idle_misalign", 32'(misalign_o), 32'd0);
    chk("idle_bus_req", 32'(bus_req_o), 32'd0);
    for (int k = 0; k <= gd; k++) begin
      @(posedge clk); #1;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'($urandom_range(0, 1));
      bus_rdata_i  = $urandom;
      @(negedge clk);
      if (mem_stall_o) stalls++;
      chk("req_bus_req", 32'(bus_req_o), 32'd1);
      chk("req_addr", bus_addr_o, a & 32'hFFFF_FFFC);
      chk("req_strb", 32'(bus_strb_o), 32'(model_strb(a, sz)));
      chk("req_we", 32'(bus_we_o), 32'(wr));
      chk("req_wdata", bus_wdata_o, exp_wdata);
      if (k == gd) bus_gnt_i = 1'b1;
    end
    if (!wr) begin
      for (int j = 0; j <= rd; j++) begin
        @(posedge clk); #1;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = $urandom;
        @(negedge clk);
        if (mem_stall_o) stalls++;
        chk("wait_bus_req", 32'(bus_req_o), 32'd0);
        if (j == rd) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rdata;
        end
      end
    end
    @(posedge clk); #1;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'($urandom_range(0, 1));
    bus_rdata_i  = $urandom;
    @(negedge clk);
    chk("done_stall", 32'(mem_stall_o), 32'd0);
    chk("done_bus_req", 32'(bus_req_o), 32'd0);
    if (!wr) model_rd = exp_q.pop_front();
    chk("rd_data", mem_rd_data_o, model_rd);
    chk("stall_cycles", 32'(stalls), wr ? 32'(2 + gd) : 32'(3 + gd + rd));
    @(posedge clk); #1;
    data_mem_req_i = 1'b0;
    bus_rvalid_i   = 1'b0;
  endtask

  // Misaligned access: flagged in the same cycle, no stall, never reaches the bus.
  task automatic misaligned(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                            input logic [31:0] wd);
    drive_req(a, sz, wr, wd);
    @(negedge clk);
    chk("mis_flag", 32'(misalign_o), 32'd1);
    chk("mis_stall", 32'(mem_stall_o), 32'd0);
    chk("mis_bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_bus_req2", 32'(bus_req_o), 32'd0);
    chk("mis_rd_hold", mem_rd_data_o, model_rd);
    @(posedge clk); #1;
    data_mem_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    // 1: reset held with gnt high; everything quiet.
    bus_gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dbg_state_o), 32'd0);
    chk("rst_rd", mem_rd_data_o, 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_we", 32'(bus_we_o), 32'd0);
    chk("rst_bus_strb", 32'(bus_strb_o), 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state_o), 32'd0);
    chk("post_rst_bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;

    // 2: byte store to the top lane, granted immediately.
    access(32'h0000_1003, 2'b00, 1'b1, 32'h0000_00A5, 0, 0, 32'd0);
    // 3: word load then halfword load from the upper half.
    access(32'h0000_2000, 2'b11, 1'b0, 32'd0, 0, 2, 32'h8765_4321);
    access(32'h0000_2002, 2'b01, 1'b0, 32'd0, 1, 0, 32'h8765_4321);
    // 4: misaligned word load.
    misaligned(32'h0000_2001, 2'b11, 1'b0, 32'd0);
    // Size 2'b10 behaves as a word.
    access(32'h0000_3004, 2'b10, 1'b1, 32'h1234_5678, 2, 0, 32'd0);

    // Randomized accesses, back to back.
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
      if (is_misaligned(a, sz))
        misaligned(a, sz, 1'($urandom_range(0, 1)), $urandom);
      else
        access(a, sz, 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // 5: reset pulsed while waiting for read data; a late rvalid is ignored.
    access(32'h0000_2000, 2'b11, 1'b0, 32'd0, 0, 0, 32'hCAFE_F00D);
    drive_req(32'h0000_3000, 2'b11, 1'b0, 32'd0);
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    chk("r5_wait_stall", 32'(mem_stall_o), 32'd1);
    reset_n        = 1'b0;
    data_mem_req_i = 1'b0;
    #1;
    chk("r5_bus_req", 32'(bus_req_o), 32'd0);
    chk("r5_stall", 32'(mem_stall_o), 32'd0);
    chk("r5_rd", mem_rd_data_o, 32'd0);
    model_rd = 32'd0;
    @(posedge clk); #1;
    reset_n      = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("r5_late_rd", mem_rd_data_o, 32'd0);
    chk("r5_late_bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("r5_idle_state", 32'(dbg_state_o), 32'd0);
    chk("r5_idle_rd", mem_rd_data_o, 32'd0);
    @(posedge clk); #1;

    // Bus still usable after the mid-transaction reset.
    access(32'h0000_5008, 2'b01, 1'b0, 32'd0, 1, 1, 32'hA1B2_C3D4);

`ifdef YARP_DMEM_TIMEOUT_EN
    // 6: load never granted; aborted after four REQ cycles.
    drive_req(32'h0000_4000, 2'b11, 1'b0, 32'd0);
    @(negedge clk);
    chk("t6_idle_stall", 32'(mem_stall_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_req_bus_req", 32'(bus_req_o), 32'd1);
      chk("t6_req_stall", 32'(mem_stall_o), 32'd1);
      chk("t6_req_err", 32'(bus_err_o), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_err_pulse", 32'(bus_err_o), 32'd1);
    chk("t6_done_stall", 32'(mem_stall_o), 32'd0);
    chk("t6_rd_zero", mem_rd_data_o, 32'd0);
    model_rd = 32'd0;
    @(posedge clk); #1;
    data_mem_req_i = 1'b0;
    @(negedge clk);
    chk("t6_err_clear", 32'(bus_err_o), 32'd0);
    chk("t6_bus_req_idle", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
`else
    // Without the timeout option the error output never rises.
    @(negedge clk);
    chk("no_err", 32'(bus_err_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
